// File: rtl/bus16_dpram32_bridge_pkg.sv
// Shared types and helpers for the 16-bit bus to 32-bit dual-port RAM bridge.
// The optional line buffer is controlled by BUS16_DPRAM32_LINEBUF_EN.
package bus16_dpram32_bridge_pkg;

  localparam int RAM_AW = 10;
  localparam int RAM_DW = 32;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } bridge_state_t;

  // lane 0 is RAM bits 15:0, lane 1 is RAM bits 31:16
  function automatic logic [3:0] lane_be(input logic lane, input logic uds, input logic lds);
    return lane ? {uds, lds, 2'b00} : {2'b00, uds, lds};
  endfunction

  function automatic logic [BUS_DW-1:0] lane_half(input logic [RAM_DW-1:0] word, input logic lane);
    return lane ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/bus16_dpram32_bridge_linebuf.sv
// One-entry read line buffer (tag, data, valid) with byte merge on local writes.
// Compiled only when BUS16_DPRAM32_LINEBUF_EN is defined.
`ifdef BUS16_DPRAM32_LINEBUF_EN
module bridge_linebuf
  import bus16_dpram32_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [RAM_AW-1:0] lookup_addr,
  output logic              hit,
  output logic [RAM_DW-1:0] data,
  input  logic              fill,
  input  logic [RAM_AW-1:0] fill_addr,
  input  logic [RAM_DW-1:0] fill_data,
  input  logic              wr,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [RAM_DW-1:0] wr_data,
  input  logic [3:0]        wr_be
);

  logic              valid;
  logic [RAM_AW-1:0] tag;
  logic [RAM_DW-1:0] line;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      tag   <= '0;
      line  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      line  <= fill_data;
    end else if (wr && valid && (wr_addr == tag)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) line[8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign hit  = valid && (lookup_addr == tag);
  assign data = line;

endmodule
`endif

// File: rtl/bus16_dpram32_bridge.sv
// Adapts 16-bit word/byte accesses with upper/lower strobes onto one port of a
// 1024x32 byte-enabled RAM. Optional read line buffer: BUS16_DPRAM32_LINEBUF_EN.
module bus16_dpram32_bridge
  import bus16_dpram32_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [10:0]       addr,
  input  logic              uds,
  input  logic              lds,
  input  logic [BUS_DW-1:0] wdata,
  output logic [BUS_DW-1:0] rdata,
  output logic              ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  input  logic [RAM_DW-1:0] ram_dout
);

  bridge_state_t     state, state_nx;
  logic              ack_nx, ram_we_nx, lane_q, lane_nx, hit_q, hit_nx;
  logic [RAM_AW-1:0] ram_addr_nx;
  logic [RAM_DW-1:0] ram_din_nx;
  logic [3:0]        ram_be_nx;
  logic [BUS_DW-1:0] rdata_hold, rdata_hold_nx;
  logic              buf_hit;
  logic [RAM_DW-1:0] buf_data;

`ifdef BUS16_DPRAM32_LINEBUF_EN
  bridge_linebuf u_linebuf (
    .clk         (clk),
    .resetn      (resetn),
    .lookup_addr (addr[10:1]),
    .hit         (buf_hit),
    .data        (buf_data),
    .fill        ((state == RD_DATA) && !hit_q),
    .fill_addr   (ram_addr),
    .fill_data   (ram_dout),
    .wr          ((state == WR) && ram_we),
    .wr_addr     (ram_addr),
    .wr_data     (ram_din),
    .wr_be       (ram_be)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_nx      = state;
    ack_nx        = 1'b0;
    ram_we_nx     = 1'b0;
    ram_addr_nx   = ram_addr;
    ram_din_nx    = ram_din;
    ram_be_nx     = ram_be;
    lane_nx       = lane_q;
    hit_nx        = 1'b0;
    rdata_hold_nx = rdata_hold;
    case (state)
      IDLE: begin
        if (req) begin
          ram_addr_nx = addr[10:1];
          ram_din_nx  = {wdata, wdata};
          ram_be_nx   = lane_be(addr[0], uds, lds);
          lane_nx     = addr[0];
          if (we) begin
            state_nx  = WR;
            ram_we_nx = uds | lds;
            ack_nx    = 1'b1;
          end else if (buf_hit) begin
            // served from the buffer: RD_DATA becomes the ack cycle, no RAM read
            state_nx      = RD_DATA;
            ack_nx        = 1'b1;
            hit_nx        = 1'b1;
            rdata_hold_nx = lane_half(buf_data, addr[0]);
          end else begin
            state_nx = RD_ADDR;
          end
        end
      end
      WR:      state_nx = IDLE;
      RD_ADDR: begin
        state_nx = RD_DATA;
        ack_nx   = 1'b1;
      end
      RD_DATA: begin
        state_nx = IDLE;
        if (!hit_q) rdata_hold_nx = lane_half(ram_dout, lane_q);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ack        <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_be     <= '0;
      lane_q     <= 1'b0;
      hit_q      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state      <= state_nx;
      ack        <= ack_nx;
      ram_we     <= ram_we_nx;
      ram_addr   <= ram_addr_nx;
      ram_din    <= ram_din_nx;
      ram_be     <= ram_be_nx;
      lane_q     <= lane_nx;
      hit_q      <= hit_nx;
      rdata_hold <= rdata_hold_nx;
    end
  end

  // The RAM output register already holds the word during RD_DATA; forward it
  // so the read acks in cycle 2, then keep the captured half until the next read.
  assign rdata = ((state == RD_DATA) && !hit_q) ? lane_half(ram_dout, lane_q) : rdata_hold;

endmodule

// File: tb/tb_bus16_dpram32_bridge.sv
// Scoreboard bench for bus16_dpram32_bridge with a read-first model RAM.
module tb_bus16_dpram32_bridge;

`ifdef BUS16_DPRAM32_LINEBUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0, we = 1'b0, uds = 1'b0, lds = 1'b0;
  logic [10:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_dout = '0;

  logic [31:0] mem [1024];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic        prev_ack = 1'b0;

  typedef struct {int cyc; logic rd; logic [15:0] data;} ack_exp_t;
  typedef struct {logic [9:0] a; logic [3:0] be; logic [31:0] din;} wr_exp_t;
  ack_exp_t ack_q[$];
  wr_exp_t  wr_q[$];

  bus16_dpram32_bridge dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .uds      (uds),
    .lds      (lds),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_be   (ram_be),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  // monitor: pops expectations whenever the DUT acks or writes the RAM
  always @(negedge clk) begin
    if (resetn) begin
      if (ack && prev_ack) check("ack_back_to_back", 1, 0);
      if (ram_we) begin
        if (wr_q.size() == 0) check("unexpected_ram_we", 1, 0);
        else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("wr_ram_addr", 32'(ram_addr), 32'(w.a));
          check("wr_ram_be", 32'(ram_be), 32'(w.be));
          check("wr_ram_din", ram_din, w.din);
          check("wr_ack_with_we", 32'(ack), 1);
        end
      end
      if (ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          ack_exp_t e;
          e = ack_q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          if (e.rd) check("rdata", 32'(rdata), 32'(e.data));
        end
      end
    end
    prev_ack = resetn && ack;
  end

  // called one tick after a rising edge with the DUT in IDLE
  task automatic access(input logic w, input logic [10:0] a, input logic u, input logic l,
                        input logic [15:0] d, input logic [15:0] exp_rd, input int lat,
                        input logic hold);
    ack_exp_t e;
    wr_exp_t  x;
    int       n;
    req = 1'b1; we = w; addr = a; uds = u; lds = l; wdata = d;
    e.cyc = cyc + lat; e.rd = !w; e.data = exp_rd;
    ack_q.push_back(e);
    if (w && (u || l)) begin
      x.a = a[10:1]; x.din = {d, d};
      x.be = a[0] ? {u, l, 2'b00} : {2'b00, u, l};
      wr_q.push_back(x);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 10);
    if (!ack) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_be"}, 32'(ram_be), 0);
    check({tag, "_ram_din"}, ram_din, 0);
    check({tag, "_rdata"}, 32'(rdata), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[2] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 11'h004, 1'b1, 1'b1, 16'h0, 16'h5678, 2, 1'b0);
    access(1'b0, 11'h005, 1'b1, 1'b1, 16'h0, 16'h1234, HIT_LAT, 1'b0);
    access(1'b1, 11'h004, 1'b0, 1'b1, 16'hAA55, 16'h0, 1, 1'b0);
    access(1'b0, 11'h004, 1'b0, 1'b1, 16'h0, 16'h5655, HIT_LAT, 1'b0);
    check("mem_word2_after_lds", mem[2], 32'h1234_5655);
    access(1'b1, 11'h005, 1'b1, 1'b0, 16'hBEEF, 16'h0, 1, 1'b0);
    access(1'b0, 11'h005, 1'b0, 1'b0, 16'h0, 16'hBE34, HIT_LAT, 1'b0);
    check("mem_word2_after_uds", mem[2], 32'hBE34_5655);
    access(1'b1, 11'h010, 1'b0, 1'b0, 16'hFFFF, 16'h0, 1, 1'b0);
    check("mem_no_strobe_write", mem[8], 32'h0);

    access(1'b1, 11'h020, 1'b1, 1'b1, 16'h1111, 16'h0, 1, 1'b1);
    access(1'b1, 11'h021, 1'b1, 1'b1, 16'h2222, 16'h0, 1, 1'b1);
    access(1'b0, 11'h020, 1'b1, 1'b1, 16'h0, 16'h1111, 2, 1'b1);
    access(1'b0, 11'h021, 1'b1, 1'b1, 16'h0, 16'h2222, HIT_LAT, 1'b1);
    access(1'b1, 11'h021, 1'b1, 1'b0, 16'h3344, 16'h0, 1, 1'b1);
    access(1'b0, 11'h021, 1'b1, 1'b1, 16'h0, 16'h3322, HIT_LAT, 1'b0);
    check("mem_word10", mem[16], 32'h3322_1111);

    // reset while the read sits in RD_ADDR
    req = 1'b1; we = 1'b0; addr = 11'h004; uds = 1'b1; lds = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1 check_zero_outputs("midreset");
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_zero_outputs("post_reset");

    access(1'b0, 11'h004, 1'b1, 1'b1, 16'h0, 16'h5655, 2, 1'b0);
    repeat (3) @(posedge clk);
    check("pending_acks", ack_q.size(), 0);
    check("pending_writes", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
